galaksija_gtp_loader: RTL and testbench

Consumes the byte stream that the data_io block delivers for tape images (OSD index 1, "TAPGTP"). It parses GTP block framing and validates Galaksija standard data blocks, then writes their payload directly into the Galaksija memory map through a request/acknowledge memory port, giving an instant load. It sits between data_io and the SDRAM arbiter inside galaksija_top, in the clk_sys domain. Tape-audio playback is a separate path and is not handled here.

---
 rtl/galaksija_gtp_loader.sv | 267 ++++++++++++++++++++++++++
 tb/tb_galaksija_gtp_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/galaksija_gtp_loader.sv
// GTP tape-image instant loader: parses GTP blocks from data_io and
// writes validated Galaksija standard-block payload through a req/ack port.
//
// Ports:
//   clk_sys, reset        rising-edge clock, synchronous active-high reset
//   ioctl_download/index  transfer window and slot select from data_io
//   ioctl_wr/addr/dout    byte strobe, file offset and file byte
//   mem_req/addr/dout     write request held until mem_ack
//   mem_ack               one-cycle acknowledge of the current request
//   busy                  load in progress or writes still pending
//   done                  last load ended cleanly (sticky)
//   error                 sticky code: 1 sync, 2 length, 3 checksum,
//                         4 FIFO overflow, 5 truncated file
//   exec_addr             start address of the last valid data block
module galaksija_gtp_loader #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] TAPE_INDEX = 8'd1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_dout,
   input  logic        mem_ack,
   output logic        busy,
   output logic        done,
   output logic [2:0]  error,
   output logic [15:0] exec_addr
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH = FIFO_DEPTH[PW:0];

   typedef enum logic [3:0] {
      S_IDLE,
      S_H_TYPE,
      S_H_LEN0,
      S_H_LEN1,
      S_H_PAD0,
      S_H_PAD1,
      S_SKIP,
      S_SYNC,
      S_A0,
      S_A1,
      S_E0,
      S_E1,
      S_DATA,
      S_CHK
   } state_t;

   state_t      state;
   logic        loading;
   logic        typ_std;
   logic [15:0] len;
   logic [15:0] cnt;
   logic [15:0] start_addr;
   logic [15:0] cur_addr;
   logic [7:0]  end_lo;
   logic [7:0]  sum;

   logic [23:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_nx;
   logic [PW:0]   count;

   logic        sel;
   logic        acc;
   logic        start;
   logic        stop;
   logic        step;
   logic        pop;
   logic        full;
   logic        push;
   logic [15:0] span;
   logic        len_ok;
   logic [7:0]  sum_nx;

   always_comb begin
      sel    = ioctl_download & (ioctl_index == TAPE_INDEX);
      acc    = ioctl_wr & sel;
      start  = acc & (ioctl_addr == 27'd0);
      // end of transfer: window closed or slot changed away
      stop   = loading & ~sel;
      step   = acc & ~start & (state != S_IDLE);
      pop    = mem_req & mem_ack;
      full   = (count == DEPTH);
      // a pop in the same cycle frees the slot, so full+pop still pushes
      push   = step & (state == S_DATA) & (~full | pop);
      span   = {ioctl_dout, end_lo} - start_addr;
      len_ok = (len == span + 16'd6);
      sum_nx = sum + ioctl_dout;
      rd_nx  = rd_ptr + 1'b1;
   end

   assign busy = loading | (count != '0) | mem_req;

   // parser
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= S_IDLE;
         loading    <= 1'b0;
         typ_std    <= 1'b0;
         len        <= '0;
         cnt        <= '0;
         start_addr <= '0;
         cur_addr   <= '0;
         end_lo     <= '0;
         sum        <= '0;
         done       <= 1'b0;
         error      <= 3'd0;
         exec_addr  <= '0;
      end else if (start) begin
         // the offset-0 byte is the first block's type byte
         loading <= 1'b1;
         done    <= 1'b0;
         error   <= 3'd0;
         typ_std <= (ioctl_dout == 8'h00);
         state   <= S_H_LEN0;
      end else if (stop) begin
         loading <= 1'b0;
         state   <= S_IDLE;
         if (state == S_H_TYPE) begin
            if (error == 3'd0) done <= 1'b1;
         end else if (state != S_IDLE) begin
            error <= 3'd5;
         end
      end else if (step) begin
         unique case (state)
            S_IDLE: ;
            S_H_TYPE: begin
               typ_std <= (ioctl_dout == 8'h00);
               state   <= S_H_LEN0;
            end
            S_H_LEN0: begin
               len[7:0] <= ioctl_dout;
               state    <= S_H_LEN1;
            end
            S_H_LEN1: begin
               len[15:8] <= ioctl_dout;
               state     <= S_H_PAD0;
            end
            S_H_PAD0: state <= S_H_PAD1;
            S_H_PAD1: begin
               if (len == 16'd0) begin
                  state <= S_H_TYPE;
               end else if (typ_std) begin
                  state <= S_SYNC;
               end else begin
                  cnt   <= len;
                  state <= S_SKIP;
               end
            end
            S_SKIP: begin
               cnt <= cnt - 16'd1;
               if (cnt == 16'd1) state <= S_H_TYPE;
            end
            S_SYNC: begin
               sum <= 8'd0;
               if (ioctl_dout == 8'hA5) begin
                  state <= S_A0;
               end else begin
                  error <= 3'd1;
                  state <= S_IDLE;
               end
            end
            S_A0: begin
               start_addr[7:0] <= ioctl_dout;
               sum             <= sum_nx;
               state           <= S_A1;
            end
            S_A1: begin
               start_addr[15:8] <= ioctl_dout;
               cur_addr         <= {ioctl_dout, start_addr[7:0]};
               sum              <= sum_nx;
               state            <= S_E0;
            end
            S_E0: begin
               end_lo <= ioctl_dout;
               sum    <= sum_nx;
               state  <= S_E1;
            end
            S_E1: begin
               sum <= sum_nx;
               cnt <= span;
               if (!len_ok) begin
                  error <= 3'd2;
                  state <= S_IDLE;
               end else if (span == 16'd0) begin
                  state <= S_CHK;
               end else begin
                  state <= S_DATA;
               end
            end
            S_DATA: begin
               if (push) begin
                  cur_addr <= cur_addr + 16'd1;
                  cnt      <= cnt - 16'd1;
                  sum      <= sum_nx;
                  if (cnt == 16'd1) state <= S_CHK;
               end else begin
                  error <= 3'd4;
                  state <= S_IDLE;
               end
            end
            S_CHK: begin
               if (sum_nx == 8'hFF) begin
                  exec_addr <= start_addr;
                  state     <= S_H_TYPE;
               end else begin
                  error <= 3'd3;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO storage, no reset needed: pointers define validity
   always_ff @(posedge clk_sys) begin
      if (push) fifo_mem[wr_ptr] <= {cur_addr, ioctl_dout};
   end

   // FIFO pointers and memory request port
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         mem_dout <= '0;
      end else if (start) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         mem_req <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop) begin
            rd_ptr <= rd_nx;
            // keep the request up only if a further entry is already stored
            if (count > (PW+1)'(1)) begin
               mem_req               <= 1'b1;
               {mem_addr, mem_dout}  <= fifo_mem[rd_nx];
            end else begin
               mem_req <= 1'b0;
            end
         end else if (!mem_req && count != '0) begin
            mem_req              <= 1'b1;
            {mem_addr, mem_dout} <= fifo_mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_galaksija_gtp_loader.sv
// Directed self-checking bench for galaksija_gtp_loader.
// Auto-acking memory model logs every write it acknowledges.
module tb_galaksija_gtp_loader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [26:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  mem_dout;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic [2:0]  error;
   logic [15:0] exec_addr;

   galaksija_gtp_loader #(.FIFO_DEPTH(4), .TAPE_INDEX(8'd1)) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_dout       (mem_dout),
      .mem_ack        (mem_ack),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .exec_addr      (exec_addr)
   );

   always #5 clk_sys = ~clk_sys;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          faddr = 0;
   bit          ack_en = 1'b0;
   logic [15:0] log_a [$];
   logic [7:0]  log_d [$];
   logic [7:0]  none [$];
   logic [7:0]  blk [$];
   logic [7:0]  exp_d [$];

   // memory model: ack whatever request is up, at the falling edge
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (mem_req === 1'b1 && ack_en) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_dout);
            mem_ack = 1'b1;
         end else begin
            mem_ack = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      ioctl_addr = 27'(faddr);
      ioctl_dout = b;
      ioctl_wr   = 1'b1;
      @(posedge clk_sys);
      #1;
      ioctl_wr = 1'b0;
      faddr++;
   endtask

   task automatic send_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) send(blk[i]);
   endtask

   task automatic begin_load();
      log_a.delete();
      log_d.delete();
      faddr          = 0;
      ioctl_index    = 8'd1;
      ioctl_download = 1'b1;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic end_load();
      ioctl_download = 1'b0;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < 200) begin
         @(posedge clk_sys);
         #1;
         k++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic chk_writes(input string tag, input logic [15:0] a0,
                             input logic [7:0] d [$]);
      chk({tag, "_n"}, log_a.size(), d.size());
      for (int i = 0; i < d.size(); i++) begin
         if (i < log_a.size()) begin
            chk({tag, "_a"}, 32'(log_a[i]), 32'(a0 + 16'(i)));
            chk({tag, "_d"}, 32'(log_d[i]), 32'(d[i]));
         end
      end
   endtask

   // valid block: 2800..2802 = 11 22 33; A0..E1 sum 0x53, data 0x66,
   // total 0xB9, so checksum byte 0x46 brings the sum to 0xFF
   task automatic set_vblk();
      blk = '{8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'hA5,
              8'h00, 8'h28, 8'h03, 8'h28,
              8'h11, 8'h22, 8'h33, 8'h46};
   endtask

   initial begin
      reset          = 1'b1;
      ioctl_download = 1'b0;
      ioctl_index    = 8'd0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      exp_d          = '{8'h11, 8'h22, 8'h33};
      repeat (3) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      @(posedge clk_sys);
      #1;
      chk("rst_req",  32'(mem_req),   32'd0);
      chk("rst_addr", 32'(mem_addr),  32'd0);
      chk("rst_dout", 32'(mem_dout),  32'd0);
      chk("rst_busy", 32'(busy),      32'd0);
      chk("rst_done", 32'(done),      32'd0);
      chk("rst_err",  32'(error),     32'd0);
      chk("rst_exec", 32'(exec_addr), 32'd0);

      // T1 valid block, first-write latency
      ack_en = 1'b1;
      set_vblk();
      begin_load();
      send_range(0, 10);
      chk("t1_lat0", 32'(mem_req), 32'd0);
      chk("t1_busy", 32'(busy),    32'd1);
      send(blk[11]);
      chk("t1_lat1",  32'(mem_req),  32'd1);
      chk("t1_laddr", 32'(mem_addr), 32'h2800);
      chk("t1_ldout", 32'(mem_dout), 32'h11);
      send_range(12, 13);
      end_load();
      chk("t1_done", 32'(done),      32'd1);
      chk("t1_err",  32'(error),     32'd0);
      chk("t1_exec", 32'(exec_addr), 32'h2800);
      drain("t1_drain");
      chk_writes("t1", 16'h2800, exp_d);

      // T2 name block skipped, then valid block
      begin_load();
      blk = '{8'h10, 8'h04, 8'h00, 8'h00, 8'h00,
              8'h47, 8'h41, 8'h4C, 8'h41};
      send_range(0, 8);
      set_vblk();
      send_range(0, 13);
      end_load();
      chk("t2_done", 32'(done),  32'd1);
      chk("t2_err",  32'(error), 32'd0);
      drain("t2_drain");
      chk_writes("t2", 16'h2800, exp_d);

      // T3 bad checksum: writes stay, error 3
      set_vblk();
      blk[13] = 8'h47;
      begin_load();
      send_range(0, 13);
      chk("t3_err_now", 32'(error), 32'd3);
      end_load();
      chk("t3_done", 32'(done),  32'd0);
      chk("t3_err",  32'(error), 32'd3);
      drain("t3_drain");
      chk_writes("t3", 16'h2800, exp_d);

      // T4 length mismatch: len 0x0A vs span 3
      set_vblk();
      blk[1] = 8'h0A;
      begin_load();
      send_range(0, 9);
      chk("t4_err_now", 32'(error), 32'd2);
      send_range(10, 13);
      end_load();
      chk("t4_done", 32'(done),  32'd0);
      chk("t4_err",  32'(error), 32'd2);
      drain("t4_drain");
      chk_writes("t4", 16'h0000, none);

      // T5 ack withheld, back-to-back data: 5th pending byte overflows
      ack_en = 1'b0;
      blk = '{8'h00, 8'h0E, 8'h00, 8'h00, 8'h00, 8'hA5,
              8'h00, 8'h30, 8'h08, 8'h30,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h73};
      begin_load();
      send_range(0, 13);
      chk("t5_req",    32'(mem_req),  32'd1);
      chk("t5_hold_a", 32'(mem_addr), 32'h3000);
      chk("t5_err0",   32'(error),    32'd0);
      send(blk[14]);
      chk("t5_ovf", 32'(error), 32'd4);
      send_range(15, 18);
      repeat (14) @(posedge clk_sys);
      #1;
      chk("t5_stable_a", 32'(mem_addr), 32'h3000);
      chk("t5_stable_d", 32'(mem_dout), 32'h01);
      end_load();
      chk("t5_busy", 32'(busy),  32'd1);
      chk("t5_done", 32'(done),  32'd0);
      chk("t5_err",  32'(error), 32'd4);
      ack_en = 1'b1;
      drain("t5_drain");
      exp_d = '{8'h01, 8'h02, 8'h03, 8'h04};
      chk_writes("t5", 16'h3000, exp_d);

      // T6 truncated inside DATA
      ack_en = 1'b0;
      blk = '{8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'hA5,
              8'h00, 8'h40, 8'h04, 8'h40, 8'hAA, 8'hBB};
      begin_load();
      send_range(0, 11);
      end_load();
      chk("t6_err",  32'(error), 32'd5);
      chk("t6_done", 32'(done),  32'd0);
      chk("t6_busy", 32'(busy),  32'd1);
      ack_en = 1'b1;
      drain("t6_drain");
      exp_d = '{8'hAA, 8'hBB};
      chk_writes("t6", 16'h4000, exp_d);

      // T7 zero-length block, then valid block; ended by index change
      begin_load();
      blk = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
      send_range(0, 4);
      set_vblk();
      send_range(0, 13);
      ioctl_index = 8'd2;
      @(posedge clk_sys);
      #1;
      chk("t7_done", 32'(done),  32'd1);
      chk("t7_err",  32'(error), 32'd0);
      drain("t7_drain");
      exp_d = '{8'h11, 8'h22, 8'h33};
      chk_writes("t7", 16'h2800, exp_d);
      ioctl_download = 1'b0;

      // T8 bad sync byte
      set_vblk();
      blk[5] = 8'hA4;
      begin_load();
      send_range(0, 5);
      chk("t8_err_now", 32'(error), 32'd1);
      end_load();
      chk("t8_done", 32'(done), 32'd0);
      drain("t8_drain");

      // T9 reset mid-load abandons the request
      ack_en = 1'b0;
      set_vblk();
      begin_load();
      send_range(0, 11);
      chk("t9_req", 32'(mem_req), 32'd1);
      reset = 1'b1;
      @(posedge clk_sys);
      #1;
      reset = 1'b0;
      chk("t9_req0",  32'(mem_req), 32'd0);
      chk("t9_busy0", 32'(busy),    32'd0);
      chk("t9_err0",  32'(error),   32'd0);
      ioctl_download = 1'b0;
      repeat (2) @(posedge clk_sys);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
